reaction_game: RTL and testbench

- Alarm-dismiss mini-game for the Basys3 alarm clock.
- Sits directly upstream of the mode FSM. It consumes the FSM's enable_game and drives the FSM's game_done, random_led and game_led_off inputs.
- Flashes a pseudo-random LED position (0..14) for a fixed window. The player must press btnC while the LED is lit, HITS_REQUIRED times in a row. Any miss resets the streak.

---
 rtl/reaction_game.sv | 123 ++++++++++++
 tb/tb_reaction_game.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_game.sv
// Alarm-dismiss reaction game: flashes a pseudo-random LED and counts consecutive in-window presses of btnC.
// Presses reach the state logic 3 clocks after the raw edge; game_done is a level held until enable drops.
module reaction_game #(
  parameter int          ON_CYCLES     = 50_000_000,
  parameter int          GAP_CYCLES    = 25_000_000,
  parameter int          HITS_REQUIRED = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       btn,
  output logic [3:0] random_led,
  output logic       game_led_off,
  output logic       game_done,
  output logic [2:0] hit_count
);

  localparam int            MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int            TW         = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] ON_LOAD    = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
  localparam logic [2:0]    HITS       = 3'(HITS_REQUIRED);

  typedef enum logic [2:0] {IDLE, ARM, GAP, SHOW, DONE} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    hit_n, hit_inc;
  logic [3:0]    led_n, cand, next_led;
  logic [15:0]   lfsr;
  logic          s1, s2, s3, press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign press = s2 & ~s3;

  // Free-running so the target sequence depends on when the player acts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign cand     = (lfsr[3:0] == 4'd15) ? 4'd0 : lfsr[3:0];
  assign next_led = (cand != random_led) ? cand : ((cand == 4'd14) ? 4'd0 : cand + 4'd1);
  assign hit_inc  = hit_count + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      hit_count  <= 3'd0;
      random_led <= 4'd0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      hit_count  <= hit_n;
      random_led <= led_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = (timer == '0) ? timer : timer - TW'(1);
    hit_n   = hit_count;
    led_n   = random_led;
    if (!enable) begin
      state_n = IDLE;
      hit_n   = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          state_n = ARM;
          hit_n   = 3'd0;
        end
        // Wait out the press that started the game before timing anything.
        ARM: begin
          if (!s2) begin
            state_n = GAP;
            timer_n = GAP_LOAD;
          end
        end
        GAP: begin
          if (press) begin
            hit_n   = 3'd0;
            timer_n = GAP_LOAD;
          end else if (timer == '0) begin
            led_n   = next_led;
            state_n = SHOW;
            timer_n = ON_LOAD;
          end
        end
        SHOW: begin
          if (press) begin
            hit_n   = hit_inc;
            state_n = (hit_inc == HITS) ? DONE : GAP;
            timer_n = GAP_LOAD;
          end else if (timer == '0) begin
            hit_n   = 3'd0;
            state_n = GAP;
            timer_n = GAP_LOAD;
          end
        end
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign game_led_off = (state != SHOW);
  assign game_done    = (state == DONE);

endmodule

// File: tb/tb_reaction_game.sv
// Scoreboard bench: stimulus queues the expected (outputs, duration) of each output run; a monitor checks every run as it ends.
module tb_reaction_game;

  logic       clk = 1'b0;
  logic       reset, enable, btn;
  logic [3:0] random_led;
  logic       game_led_off, game_done;
  logic [2:0] hit_count;
  logic [4:0] tup;

  reaction_game #(.ON_CYCLES(20), .GAP_CYCLES(10), .HITS_REQUIRED(3), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .btn(btn),
    .random_led(random_led), .game_led_off(game_led_off),
    .game_done(game_done), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  // {game_led_off, game_done, hit_count}
  assign tup = {game_led_off, game_done, hit_count};
  localparam logic [4:0] D0 = 5'b10_000, D1 = 5'b10_001, D2 = 5'b10_010;
  localparam logic [4:0] S0 = 5'b00_000, S1 = 5'b00_001, S2 = 5'b00_010;
  localparam logic [4:0] DN = 5'b11_011;

  typedef struct { logic [4:0] tup; int len; } exp_t;
  exp_t       exp_q[$];
  logic [3:0] led_log[$];
  int         checks = 0;
  int         errors = 0;

  task automatic push(input logic [4:0] t, input int n);
    exp_t e;
    e.tup = t;
    e.len = n;
    exp_q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_show;
    int n;
    n = 0;
    while (game_led_off !== 1'b1 && n < 200) begin tick; n++; end
    while (game_led_off !== 1'b0 && n < 400) begin tick; n++; end
    checks++;
    if (game_led_off !== 1'b0) begin
      errors++;
      $display("FAIL wait_show: game_led_off=%b after %0d cycles, required 0", game_led_off, n);
    end
  endtask

  // Press lands 3 clocks after the raw edge, i.e. on the 6th SHOW clock.
  task automatic hit;
    wait_show;
    repeat (2) tick;
    btn = 1'b1;
    tick;
    btn = 1'b0;
  endtask

  task automatic t1_arm_and_miss;
    push(D0, 21); push(S0, 20); push(D0, 10);
    btn = 1'b1;
    repeat (3) tick;
    enable = 1'b1;
    repeat (5) tick;
    btn = 1'b0;
    wait_show;
  endtask

  task automatic t2_three_hits;
    push(S0, 5); push(D1, 10); push(S1, 5); push(D2, 10); push(S2, 5); push(DN, 5);
    hit; hit; hit;
    repeat (6) tick;
    enable = 1'b0;
    tick;
  endtask

  task automatic reenable;
    push(D0, 12);
    enable = 1'b1;
  endtask

  initial begin : monitor
    logic [4:0] prev;
    logic [3:0] prev_led, show_led;
    int         run;
    exp_t       e;
    prev = D0; prev_led = 4'd0; show_led = 4'd0; run = 0;
    forever begin
      @(negedge clk);
      if (tup !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: run %b for %0d cycles ended, nothing expected", prev, run);
        end else begin
          e = exp_q.pop_front();
          if (e.tup !== prev || e.len != run) begin
            errors++;
            $display("FAIL sb_run: got %b for %0d cycles, required %b for %0d cycles", prev, run, e.tup, e.len);
          end
        end
        if (tup[4] == 1'b0 && !reset) begin
          checks++;
          if (random_led == 4'd15) begin
            errors++;
            $display("FAIL led_range: random_led=%0d, required 0..14", random_led);
          end
          checks++;
          if (random_led == prev_led) begin
            errors++;
            $display("FAIL led_repeat: random_led=%0d, required different from previous %0d", random_led, prev_led);
          end
          prev_led = random_led;
          show_led = random_led;
          led_log.push_back(random_led);
        end
        prev = tup;
        run  = 0;
      end else if (tup[4] == 1'b0) begin
        checks++;
        if (random_led !== show_led) begin
          errors++;
          $display("FAIL led_stable: random_led=%0d mid-SHOW, required %0d", random_led, show_led);
        end
      end
      if (reset) prev_led = 4'd0;
      else       run++;
    end
  end

  initial begin : stimulus
    int base;
    reset = 1'b1; enable = 1'b0; btn = 1'b0;
    repeat (2) tick;
    reset = 1'b0;

    t1_arm_and_miss;
    t2_three_hits;

    // Hit, hit, then a press in the dark gap breaks the streak and restarts the gap.
    reenable;
    push(S0, 5); push(D1, 10); push(S1, 5); push(D2, 5); push(D0, 10);
    hit; hit;
    repeat (4) tick;
    btn = 1'b1;
    tick;
    btn = 1'b0;

    // Hit, then let a whole SHOW window time out.
    push(S0, 5); push(D1, 10); push(S1, 20); push(D0, 10);
    hit;
    wait_show;

    for (int i = 0; i < 200; i++) begin
      if (i < 199) begin push(S0, 20); push(D0, 10); end
      else push(S0, 2);
      wait_show;
    end

    // Asynchronous reset two clocks into a SHOW window.
    repeat (2) tick;
    reset = 1'b1;
    #1;
    checks++;
    if ({game_led_off, game_done, hit_count, random_led} !== 9'b1_0_000_0000) begin
      errors++;
      $display("FAIL async_reset: off=%b done=%b hits=%0d led=%0d, required 1 0 0 0",
               game_led_off, game_done, hit_count, random_led);
    end
    base = led_log.size();
    enable = 1'b0;
    btn = 1'b0;
    repeat (2) tick;
    reset = 1'b0;

    t1_arm_and_miss;
    t2_three_hits;

    // Drop enable one clock into the gap after the second hit.
    reenable;
    push(S0, 5); push(D1, 10); push(S1, 5); push(D2, 1);
    hit; hit;
    repeat (2) tick;
    enable = 1'b0;
    repeat (5) tick;

    checks++;
    if (tup !== D0) begin
      errors++;
      $display("FAIL idle_after_drop: outputs %b, required %b", tup, D0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d runs never seen, required 0", exp_q.size());
    end
    checks++;
    if (base != 208) begin
      errors++;
      $display("FAIL round_count: %0d SHOW windows before reset, required 208", base);
    end
    checks++;
    if (led_log.size() != base + 6) begin
      errors++;
      $display("FAIL replay_count: %0d SHOW windows after reset, required 6", led_log.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (led_log[base + i] !== led_log[i]) begin
          errors++;
          $display("FAIL replay_led%0d: random_led=%0d after reset, required %0d", i, led_log[base + i], led_log[i]);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors + 0);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, required to finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
